uart_dir_queue: RTL and testbench
=================================

# uart_dir_queue

Parametrised successor to the snake game's UART key decoder. Classifies each received UART byte as a direction, pause or unknown command. Accepted direction commands go into a small FIFO that the game engine drains on its own move strobe, so several direction presses within one snake step are applied in order instead of being lost. Reversal and duplicate commands are filtered, pause is tracked, and legacy one-cycle key pulses are kept for existing consumers.

## Interface
- FIFO_DEPTH, 4: direction queue depth; power of two, ≥2
- ASCII_EN, 1: also accept 'w/W','s/S','a/A','d/D' as directions and 'p/P' as pause
- CODE_UP, 8'd5: numeric up code
- CODE_DOWN, 8'd2: numeric down code
- CODE_LEFT, 8'd1: numeric left code
- CODE_RIGHT, 8'd3: numeric right code
- CODE_PAUSE, 8'd4: numeric pause-toggle code
- REJECT_REVERSE, 1: drop a direction opposite to the last one
- INIT_DIR, 2'd3: heading after reset or clear (0 up, 1 down, 2 left, 3 right)

Ports:
- lcd_pclk  in  1  the only clock
- rst_n  in  1  reset, synchronous, active-low
- rx_data_t  in  8  received byte; valid only when rx_data_done=1
- rx_data_done  in  1  one-cycle byte strobe
- move_tick  in  1  game step strobe; pops one queued direction
- clear  in  1  game restart; flushes state
- key_up, key_down, key_left, key_right  out  1 each  one-cycle pulse per accepted direction
- dir  out  2  current applied heading
- paused  out  1  pause level
- fifo_count  out  $clog2(FIFO_DEPTH+1)  queued entries
- drop_pulse  out  1  one-cycle pulse when a recognised command is rejected

## Operation
- Reset (rst_n=0 at an edge) sets dir=INIT_DIR. All other outputs go to 0. The FIFO is emptied.
- Priority per cycle: reset > clear > normal operation.
- clear has the same effect as reset. Any rx_data_done or move_tick in the same cycle is ignored.
- Classification at rx_data_done=1:
  - Numeric codes are compared first, then ASCII codes when ASCII_EN=1.
  - Any other byte is ignored: no pulse and no drop_pulse.
- last = FIFO tail entry when fifo_count>0; otherwise dir. Use values registered before the cycle.
- A direction command d is accepted only if all of these hold:
  - paused=0
  - d≠last
  - REJECT_REVERSE=0, or d is not the opposite of last (opposites: up/down, left/right, i.e. same bit1, different bit0)
  - fifo_count<FIFO_DEPTH, using the pre-cycle count; a pop in the same cycle does not free a slot
- Accepted command: d is written at the tail and the matching key_* pulse fires.
- Rejected direction command: drop_pulse fires.
- Pause code: paused toggles; no drop_pulse.
- move_tick=1 with paused=0 and pre-cycle fifo_count>0: dir ← head entry and the entry is popped.
- move_tick while paused or with an empty FIFO: no effect.
- Push and pop in the same cycle: fifo_count is unchanged. With pre-cycle count 0, only the push happens.
- Pausing keeps the queue contents. Unpausing resumes draining on the next move_tick.

## Timing
- All outputs are registered.
- rx_data_done at edge N gives key_*, drop_pulse, paused and fifo_count updates visible after edge N, i.e. in cycle N+1.
- At most one key_* pulse is high in any cycle. Pulses last exactly one cycle.
- move_tick at edge N gives updated dir and fifo_count in cycle N+1.
- Back-to-back rx_data_done on consecutive cycles is supported. Each byte is checked against the last value that includes the previous cycle's push.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Test plan
- Reset then byte 8'd5 → key_up pulses 1 cycle, fifo_count=1; move_tick → dir=0, fifo_count=0.
- With dir=3, send 'a' (0x61) → drop_pulse and no key pulse (reverse); send 'w','a' → both queued; two move_ticks → dir=0 then dir=2.
- Send 5 distinct non-reversing directions with no tick at FIFO_DEPTH=4 → 4 accepted, 5th gives drop_pulse, fifo_count=4; tick while full plus push in the same cycle → push dropped, count=3.
- Send 8'd4 → paused=1; a direction byte → drop_pulse; move_tick → dir unchanged; 'p' → paused=0.
- Queue 2 entries, assert clear together with rx_data_done → fifo_count=0, dir=3, paused=0, no pulse.
- Bytes 0x00 and 0x7F → no key pulse, no drop_pulse, state unchanged; repeat with ASCII_EN=0 and 'w' → ignored.

Source files
------------

// File: rtl/uart_dir_queue.sv
// uart_dir_queue: classifies UART bytes into direction / pause commands
// and queues accepted directions for the game engine's move strobe.
// Ports: lcd_pclk, rst_n (sync, active-low), rx_data_t/rx_data_done (byte in),
//   move_tick (pop strobe), clear (restart), key_* (accept pulses), dir,
//   paused, fifo_count, drop_pulse (rejected recognised command).
module uart_dir_queue #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter bit          ASCII_EN       = 1'b1,
   parameter logic [7:0]  CODE_UP        = 8'd5,
   parameter logic [7:0]  CODE_DOWN      = 8'd2,
   parameter logic [7:0]  CODE_LEFT      = 8'd1,
   parameter logic [7:0]  CODE_RIGHT     = 8'd3,
   parameter logic [7:0]  CODE_PAUSE     = 8'd4,
   parameter bit          REJECT_REVERSE = 1'b1,
   parameter logic [1:0]  INIT_DIR       = 2'd3,
   localparam int         CW             = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          lcd_pclk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data_t,
   input  logic          rx_data_done,
   input  logic          move_tick,
   input  logic          clear,
   output logic          key_up,
   output logic          key_down,
   output logic          key_left,
   output logic          key_right,
   output logic [1:0]    dir,
   output logic          paused,
   output logic [CW-1:0] fifo_count,
   output logic          drop_pulse
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [1:0]    mem_q [FIFO_DEPTH];
   logic [1:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fifo_count_q, fifo_count_d;
   logic [1:0]    dir_q, dir_d;
   logic          paused_q, paused_d;
   logic [3:0]    key_q, key_d;
   logic          drop_q, drop_d;

   logic          is_dir;
   logic          is_pause;
   logic [1:0]    cmd_dir;
   logic [PW-1:0] tail_ptr;
   logic [1:0]    last;
   logic          reverse;
   logic          push;
   logic          pop;

   // Numeric codes win over ASCII letters when both could match.
   always_comb begin
      is_dir   = 1'b0;
      is_pause = 1'b0;
      cmd_dir  = 2'd0;
      if (rx_data_t == CODE_UP) begin
         is_dir  = 1'b1;
         cmd_dir = 2'd0;
      end else if (rx_data_t == CODE_DOWN) begin
         is_dir  = 1'b1;
         cmd_dir = 2'd1;
      end else if (rx_data_t == CODE_LEFT) begin
         is_dir  = 1'b1;
         cmd_dir = 2'd2;
      end else if (rx_data_t == CODE_RIGHT) begin
         is_dir  = 1'b1;
         cmd_dir = 2'd3;
      end else if (rx_data_t == CODE_PAUSE) begin
         is_pause = 1'b1;
      end else if (ASCII_EN) begin
         case (rx_data_t)
            8'h77, 8'h57: begin is_dir = 1'b1; cmd_dir = 2'd0; end
            8'h73, 8'h53: begin is_dir = 1'b1; cmd_dir = 2'd1; end
            8'h61, 8'h41: begin is_dir = 1'b1; cmd_dir = 2'd2; end
            8'h64, 8'h44: begin is_dir = 1'b1; cmd_dir = 2'd3; end
            8'h70, 8'h50: is_pause = 1'b1;
            default: ;
         endcase
      end
   end

   // New commands are compared with the newest queued heading, so a
   // burst of presses is filtered against what will actually be applied.
   always_comb begin
      tail_ptr = wr_ptr_q - 1'b1;
      last     = (fifo_count_q != '0) ? mem_q[tail_ptr] : dir_q;
      reverse  = REJECT_REVERSE &&
                 (cmd_dir[1] == last[1]) && (cmd_dir[0] != last[0]);
      push     = rx_data_done && is_dir && !paused_q &&
                 (cmd_dir != last) && !reverse &&
                 (fifo_count_q < DEPTH_C);
      pop      = move_tick && !paused_q && (fifo_count_q != '0);
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_count_d = fifo_count_q;
      dir_d        = dir_q;
      paused_d     = paused_q;
      key_d        = 4'b0000;
      drop_d       = 1'b0;
      if (clear) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         fifo_count_d = '0;
         dir_d        = INIT_DIR;
         paused_d     = 1'b0;
      end else begin
         if (rx_data_done && is_pause) begin
            paused_d = ~paused_q;
         end
         if (push) begin
            mem_d[wr_ptr_q] = cmd_dir;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            key_d           = 4'b0001 << cmd_dir;
         end else if (rx_data_done && is_dir) begin
            drop_d = 1'b1;
         end
         if (pop) begin
            dir_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
         endcase
      end
   end

   always_ff @(posedge lcd_pclk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 2'd0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
         dir_q        <= INIT_DIR;
         paused_q     <= 1'b0;
         key_q        <= 4'b0000;
         drop_q       <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
         dir_q        <= dir_d;
         paused_q     <= paused_d;
         key_q        <= key_d;
         drop_q       <= drop_d;
      end
   end

   assign key_up     = key_q[0];
   assign key_down   = key_q[1];
   assign key_left   = key_q[2];
   assign key_right  = key_q[3];
   assign dir        = dir_q;
   assign paused     = paused_q;
   assign fifo_count = fifo_count_q;
   assign drop_pulse = drop_q;

endmodule

// File: tb/tb_uart_dir_queue.sv
// tb_uart_dir_queue: randomized and directed checks of uart_dir_queue
// against a queue-based command model.
module tb_uart_dir_queue;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data_t = 8'd0;
   logic       rx_data_done = 1'b0;
   logic       move_tick = 1'b0;
   logic       clear = 1'b0;

   logic       key_up, key_down, key_left, key_right;
   logic [1:0] dir;
   logic       paused;
   logic [2:0] fifo_count;
   logic       drop_pulse;

   logic       b_up, b_down, b_left, b_right;
   logic [1:0] b_dir;
   logic       b_paused;
   logic [2:0] b_count;
   logic       b_drop;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   uart_dir_queue u_dut (
      .lcd_pclk(clk), .rst_n(rst_n),
      .rx_data_t(rx_data_t), .rx_data_done(rx_data_done),
      .move_tick(move_tick), .clear(clear),
      .key_up(key_up), .key_down(key_down),
      .key_left(key_left), .key_right(key_right),
      .dir(dir), .paused(paused),
      .fifo_count(fifo_count), .drop_pulse(drop_pulse)
   );

   uart_dir_queue #(.ASCII_EN(1'b0)) u_noascii (
      .lcd_pclk(clk), .rst_n(rst_n),
      .rx_data_t(rx_data_t), .rx_data_done(rx_data_done),
      .move_tick(move_tick), .clear(clear),
      .key_up(b_up), .key_down(b_down),
      .key_left(b_left), .key_right(b_right),
      .dir(b_dir), .paused(b_paused),
      .fifo_count(b_count), .drop_pulse(b_drop)
   );

   // Reference model: the game's view of the command queue.
   logic [1:0] mq [$];
   logic [1:0] mdir = 2'd3;
   bit         mpaused = 1'b0;
   logic [3:0] ek = 4'b0;
   bit         ed = 1'b0;
   int         opp [4] = '{1, 0, 3, 2};

   function automatic void classify(input logic [7:0] b,
                                    output int kind, output int d);
      kind = 1;
      d    = 0;
      case (b)
         8'd5: d = 0;
         8'd2: d = 1;
         8'd1: d = 2;
         8'd3: d = 3;
         8'd4: kind = 2;
         "w", "W": d = 0;
         "s", "S": d = 1;
         "a", "A": d = 2;
         "d", "D": d = 3;
         "p", "P": kind = 2;
         default: kind = 0;
      endcase
   endfunction

   function automatic logic [10:0] obs();
      return {key_right, key_left, key_down, key_up,
              drop_pulse, paused, dir, fifo_count};
   endfunction

   function automatic logic [10:0] exp_vec();
      return {ek, ed, mpaused, mdir, 3'(mq.size())};
   endfunction

   function automatic logic [10:0] mk(input bit v, input logic [7:0] b,
                                      input bit t, input bit c);
      return {v, t, c, b};
   endfunction

   // Applies one cycle of stimulus to the DUT and advances the model.
   task automatic drive(input logic [10:0] s);
      int kind, d, n;
      logic [1:0] last;
      bit pop, push;
      rx_data_done = s[10];
      move_tick    = s[9];
      clear        = s[8];
      rx_data_t    = s[7:0];
      ek = 4'b0;
      ed = 1'b0;
      if (s[8]) begin
         mq.delete();
         mdir    = 2'd3;
         mpaused = 1'b0;
      end else begin
         n    = mq.size();
         last = (n > 0) ? mq[n-1] : mdir;
         pop  = s[9] && !mpaused && n > 0;
         push = 1'b0;
         classify(s[7:0], kind, d);
         if (s[10] && kind == 1) begin
            if (!mpaused && d != int'(last) && opp[d] != int'(last) && n < 4) begin
               push  = 1'b1;
               ek[d] = 1'b1;
            end else begin
               ed = 1'b1;
            end
         end
         if (pop) mdir = mq.pop_front();
         if (push) mq.push_back(2'(d));
         if (s[10] && kind == 2) mpaused = !mpaused;
      end
      @(posedge clk);
      #1;
      rx_data_done = 1'b0;
      move_tick    = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      rx_data_done = 1'b1;
      rx_data_t    = 8'd5;
      move_tick    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();
      mdir = 2'd3; mpaused = 1'b0; ek = 4'b0; ed = 1'b0;
      ntests++;
      if (obs() !== exp_vec()) begin
         nfail++;
         $display("FAIL reset got=%h exp=%h", obs(), exp_vec());
      end
      rst_n = 1'b1;
      rx_data_done = 1'b0;
      move_tick = 1'b0;
   endtask

   task automatic test_up();
      logic [10:0] s [4];
      s = '{mk(1, 8'd5, 0, 0), mk(0, 0, 0, 0),
            mk(0, 0, 1, 0), mk(0, 0, 0, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL up[%0d] got=%h exp=%h", i, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_reverse();
      logic [10:0] s [6];
      s = '{mk(0, 0, 0, 1), mk(1, "a", 0, 0), mk(1, "w", 0, 0),
            mk(1, "a", 0, 0), mk(0, 0, 1, 0), mk(0, 0, 1, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL reverse[%0d] got=%h exp=%h", i, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_full();
      logic [10:0] s [8];
      s = '{mk(0, 0, 0, 1), mk(1, "w", 0, 0), mk(1, "a", 0, 0),
            mk(1, "s", 0, 0), mk(1, "d", 0, 0), mk(1, "w", 0, 0),
            mk(1, "s", 1, 0), mk(0, 0, 0, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL full[%0d] got=%h exp=%h", i, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_pause();
      logic [10:0] s [7];
      s = '{mk(0, 0, 0, 1), mk(1, "w", 0, 0), mk(1, 8'd4, 0, 0),
            mk(1, "a", 0, 0), mk(0, 0, 1, 0), mk(1, "p", 0, 0),
            mk(0, 0, 1, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL pause[%0d] got=%h exp=%h", i, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_clear();
      logic [10:0] s [4];
      s = '{mk(1, "w", 0, 0), mk(1, "a", 0, 0),
            mk(1, "s", 1, 1), mk(0, 0, 0, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL clear[%0d] got=%h exp=%h", i, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_ignore();
      logic [10:0] s [3];
      s = '{mk(1, 8'h00, 0, 0), mk(1, 8'h7f, 0, 0), mk(1, 8'hff, 0, 0)};
      foreach (s[i]) begin
         drive(s[i]);
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL ignore[%0d] got=%h exp=%h", i, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_no_ascii();
      drive(mk(0, 0, 0, 1));
      drive(mk(1, "w", 0, 0));
      ntests++;
      if ({b_right, b_left, b_down, b_up, b_drop, b_count} !== 8'd0) begin
         nfail++;
         $display("FAIL noascii_w got=%b exp=0",
                  {b_right, b_left, b_down, b_up, b_drop, b_count});
      end
      ntests++;
      if (obs() !== exp_vec()) begin
         nfail++;
         $display("FAIL ascii_w got=%h exp=%h", obs(), exp_vec());
      end
      drive(mk(1, 8'd5, 0, 0));
      ntests++;
      if ({b_up, b_drop, b_count} !== 5'b10001) begin
         nfail++;
         $display("FAIL noascii_num got=%b exp=10001", {b_up, b_drop, b_count});
      end
   endtask

   task automatic test_random();
      logic [7:0] letters [10];
      logic [7:0] b;
      int r;
      letters = '{"w", "W", "s", "S", "a", "A", "d", "D", "p", "P"};
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      b = 8'($urandom_range(1, 5));
         else if (r < 8) b = letters[$urandom_range(0, 9)];
         else            b = 8'($urandom);
         drive(mk($urandom_range(0, 2) != 0, b,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0));
         ntests++;
         if (obs() !== exp_vec()) begin
            nfail++;
            $display("FAIL random[%0d] byte=%h got=%h exp=%h",
                     i, b, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_up();
      test_reverse();
      test_full();
      test_pause();
      test_clear();
      test_ignore();
      test_no_ascii();
      test_random();
      test_reset();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
